// File: rtl/cnt_pkt_pkg.sv
// Shared definitions for the counter packet sender: packet field offsets,
// counter count/width and the FSM state encoding.
package cnt_pkt_pkg;

  localparam int NUM_CNT     = 4;
  localparam int CNT_W       = 32;
  localparam int IDX_W       = 4;

  localparam int VALID_BIT   = 48;
  localparam int DLEAF_LSB   = 45;
  localparam int DPORT_LSB   = 41;
  localparam int IDX_LSB     = 37;
  localparam int SLEAF_LSB   = 34;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    HOLD   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } cnt_state_t;

endpackage

// File: rtl/cnt_packet_sender_if.sv
// BFT-side link of the counter packet sender: outbound user stream in,
// merged stream out, and the BFT's per-cycle reject.
interface cnt_packet_sender_if #(
  parameter int PACKET_BITS = 49
);
  logic [PACKET_BITS-1:0] stream_in;
  logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
  logic                   resend;

  modport master (
    input  stream_in,
    input  resend,
    output dout_leaf_interface2bft
  );

  modport slave (
    output stream_in,
    output resend,
    input  dout_leaf_interface2bft
  );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous input and flags 0->1 changes.
module rise_detect #(
  parameter int data_width = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] rise
);
  logic [data_width-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= din;
  end

  assign rise = din & ~prev_q;
endmodule

// File: rtl/cnt_packet_sender.sv
// Counts kernel activity between ap_start and done, then injects four counter
// packets into idle BFT slots after a fixed holdoff.
module cnt_packet_sender
  import cnt_pkt_pkg::*;
#(
  parameter int PACKET_BITS    = 49,
  parameter int NUM_LEAF_BITS  = 3,
  parameter int NUM_PORT_BITS  = 4,
  parameter int SELF_LEAF      = 2,
  parameter int DEST_LEAF      = 1,
  parameter int DEST_PORT      = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  input  logic                       done,
  input  logic                       in_vld,
  input  logic                       in_ack,
  input  logic                       out_vld,
  input  logic                       out_ack,
  cnt_packet_sender_if.master        bft,
  output logic                       busy
);
  localparam int SEL_W = $clog2(NUM_CNT);
  localparam int TMR_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  cnt_state_t             state_q;
  logic [SEL_W-1:0]       idx_q;
  logic [TMR_W-1:0]       timer_q;
  logic [CNT_W-1:0]       cnt_cycles_q, cnt_in_q, cnt_out_q, cnt_stall_q;
  logic [CNT_W-1:0]       lat_q   [NUM_CNT];
  logic [CNT_W-1:0]       cnt_nxt [NUM_CNT];
  logic                   start_rise;
  logic                   cnt_slot;
  logic [PACKET_BITS-1:0] cnt_pkt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  rise_detect #(.data_width(1)) u_rise (
    .clk   (clk),
    .reset (reset),
    .din   (ap_start),
    .rise  (start_rise)
  );

  always_comb begin
    cnt_nxt[0] = sat_inc(cnt_cycles_q, 1'b1);
    cnt_nxt[1] = sat_inc(cnt_in_q,     in_vld  & in_ack);
    cnt_nxt[2] = sat_inc(cnt_out_q,    out_vld & out_ack);
    cnt_nxt[3] = sat_inc(cnt_stall_q,  out_vld & ~out_ack);
  end

  // Counter packets only take slots the user stream leaves empty.
  always_comb begin
    cnt_pkt                                = '0;
    cnt_pkt[VALID_BIT]                     = 1'b1;
    cnt_pkt[DLEAF_LSB +: NUM_LEAF_BITS]    = NUM_LEAF_BITS'(DEST_LEAF);
    cnt_pkt[DPORT_LSB +: NUM_PORT_BITS]    = NUM_PORT_BITS'(DEST_PORT);
    cnt_pkt[IDX_LSB +: IDX_W]              = IDX_W'(idx_q);
    cnt_pkt[SLEAF_LSB +: NUM_LEAF_BITS]    = NUM_LEAF_BITS'(SELF_LEAF);
    cnt_pkt[PAYLOAD_LSB +: CNT_W]          = lat_q[idx_q];
    cnt_slot = (state_q == SEND) && !reset && !bft.stream_in[VALID_BIT];
    bft.dout_leaf_interface2bft = cnt_slot ? cnt_pkt : bft.stream_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      cnt_cycles_q <= '0;
      cnt_in_q     <= '0;
      cnt_out_q    <= '0;
      cnt_stall_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) lat_q[i] <= '0;
      busy         <= 1'b0;
    end else if (start_rise) begin
      // A new kernel run abandons whatever burst was in flight.
      state_q      <= COUNT;
      idx_q        <= '0;
      timer_q      <= '0;
      cnt_cycles_q <= '0;
      cnt_in_q     <= '0;
      cnt_out_q    <= '0;
      cnt_stall_q  <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        COUNT: begin
          cnt_cycles_q <= cnt_nxt[0];
          cnt_in_q     <= cnt_nxt[1];
          cnt_out_q    <= cnt_nxt[2];
          cnt_stall_q  <= cnt_nxt[3];
          if (done) begin
            for (int i = 0; i < NUM_CNT; i++) lat_q[i] <= cnt_nxt[i];
            timer_q <= '0;
            state_q <= HOLD;
            busy    <= 1'b1;
          end
        end
        HOLD: begin
          if (timer_q == TMR_W'(HOLDOFF_CYCLES - 1)) begin
            state_q <= SEND;
            idx_q   <= '0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        SEND: begin
          if (cnt_slot && !bft.resend) begin
            if (idx_q == SEL_W'(NUM_CNT - 1)) begin
              state_q <= FINISH;
              idx_q   <= '0;
              busy    <= 1'b0;
            end else begin
              idx_q <= idx_q + SEL_W'(1);
            end
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnt_packet_sender.sv
// Self-checking bench for cnt_packet_sender: reset/idle vector table, directed
// burst scenarios, and a randomized run against a transaction-level model.
module tb_cnt_packet_sender;
  import cnt_pkt_pkg::*;

  localparam int PB   = 49;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic reset, ap_start, done, in_vld, in_ack, out_vld, out_ack, busy;

  cnt_packet_sender_if #(.PACKET_BITS(PB)) bft ();

  cnt_packet_sender #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .ap_start (ap_start),
    .done     (done),
    .in_vld   (in_vld),
    .in_ack   (in_ack),
    .out_vld  (out_vld),
    .out_ack  (out_ack),
    .bft      (bft.master),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // staged stimulus, applied to the DUT on the falling edge
  logic s_rst, s_ap, s_dn, s_iv, s_ia, s_ov, s_oa, s_rs;
  logic [PB-1:0] s_sin;

  // reference model: phase 0 idle, 1 counting, 2 holdoff, 3 sending, 4 finish
  int            m_phase;
  logic [63:0]   m_cnt [4];
  logic          m_prev;
  int            m_hold;
  logic [PB-1:0] m_q [$];

  logic [PB-1:0] acc [$];
  logic [PB-1:0] pres [$];
  logic [PB-1:0] last_dout;
  logic          last_busy;

  typedef struct {
    logic          rst;
    logic          dn;
    logic [PB-1:0] sin;
    logic [PB-1:0] exp_dout;
    logic          exp_busy;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [PB-1:0] mk_pkt(int idx, logic [31:0] v);
    logic [3:0] ix;
    ix = 4'(idx);
    return {1'b1, 3'd1, 4'd2, ix, 3'd2, 2'b00, v};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic rise;
    rise = s_ap && !m_prev;
    if (s_rst) begin
      m_phase = 0; m_prev = 1'b0; m_q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else begin
      m_prev = s_ap;
      if (rise) begin
        m_phase = 1; m_q.delete();
        for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      end else begin
        case (m_phase)
          1: begin
            if (m_cnt[0] < 64'hFFFF_FFFF) m_cnt[0]++;
            if (s_iv && s_ia && m_cnt[1] < 64'hFFFF_FFFF) m_cnt[1]++;
            if (s_ov && s_oa && m_cnt[2] < 64'hFFFF_FFFF) m_cnt[2]++;
            if (s_ov && !s_oa && m_cnt[3] < 64'hFFFF_FFFF) m_cnt[3]++;
            if (s_dn) begin
              for (int i = 0; i < 4; i++) m_q.push_back(mk_pkt(i, m_cnt[i][31:0]));
              m_phase = 2; m_hold = HOLD;
            end
          end
          2: begin m_hold--; if (m_hold == 0) m_phase = 3; end
          3: if (!s_sin[48] && !s_rs) begin
               m_q.delete(0);
               if (m_q.size() == 0) m_phase = 4;
             end
          4: m_phase = 0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic cyc();
    logic [PB-1:0] exp;
    @(negedge clk);
    reset = s_rst; ap_start = s_ap; done = s_dn;
    in_vld = s_iv; in_ack = s_ia; out_vld = s_ov; out_ack = s_oa;
    bft.stream_in = s_sin; bft.resend = s_rs;
    #1;
    exp = s_sin;
    if (!s_rst && m_phase == 3 && !s_sin[48] && m_q.size() > 0) exp = m_q[0];
    last_dout = bft.dout_leaf_interface2bft;
    last_busy = busy;
    chk("dout", 64'(last_dout), 64'(exp));
    chk("busy", 64'(last_busy), 64'(m_phase == 2 || m_phase == 3));
    if (!s_rst && m_phase == 3 && !s_sin[48]) begin
      pres.push_back(last_dout);
      if (!s_rs) acc.push_back(last_dout);
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic quiet();
    s_dn = 0; s_iv = 0; s_ia = 0; s_ov = 0; s_oa = 0; s_rs = 0; s_sin = '0;
  endtask

  // rise, ncount random counting cycles, done, then run to the first SEND cycle
  task automatic start_burst(int ncount);
    quiet(); s_ap = 0; cyc();
    s_ap = 1; cyc();
    s_ap = 0;
    for (int k = 0; k < ncount; k++) begin
      s_iv = 1'($urandom); s_ia = 1'($urandom); s_ov = 1'($urandom); s_oa = 1'($urandom);
      cyc();
    end
    quiet(); s_dn = 1; cyc(); s_dn = 0;
    for (int k = 0; k < HOLD + 4 && m_phase != 3; k++) cyc();
    acc.delete(); pres.delete();
  endtask

  task automatic drain(int limit);
    for (int k = 0; k < limit && m_phase != 0; k++) cyc();
  endtask

  initial begin
    logic [31:0] s1_exp [4];
    int n_pass, n_idx1, n_leak;
    s1_exp[0] = 32'd101; s1_exp[1] = 32'd40; s1_exp[2] = 32'd30; s1_exp[3] = 32'd5;
    m_phase = 0; m_prev = 0; m_hold = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    reset = 1; ap_start = 0; done = 0; in_vld = 0; in_ack = 0; out_vld = 0; out_ack = 0;
    bft.stream_in = '0; bft.resend = 0;
    quiet(); s_rst = 1; s_ap = 0;

    tbl[0] = '{1'b1, 1'b0, 49'h1_2345_6789_ABCD, 49'h1_2345_6789_ABCD, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 49'h0_0000_0000_0000, 49'h0_0000_0000_0000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 49'h0_DEAD_BEEF_0001, 49'h0_DEAD_BEEF_0001, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 49'h1_0000_0000_0000, 49'h1_0000_0000_0000, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 49'h0_5A5A_A5A5_3C3C, 49'h0_5A5A_A5A5_3C3C, 1'b0};

    cyc(); cyc();
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    chk("rst_idx", 64'(dut.idx_q), 64'd0);
    chk("rst_timer", 64'(dut.timer_q), 64'd0);
    chk("rst_cnt0", 64'(dut.cnt_cycles_q), 64'd0);
    chk("rst_edge", 64'(dut.u_rise.prev_q), 64'd0);

    // reset passthrough and done ignored while idle
    foreach (tbl[i]) begin
      s_rst = tbl[i].rst; s_dn = tbl[i].dn; s_sin = tbl[i].sin;
      cyc();
      chk("tbl_dout", 64'(last_dout), 64'(tbl[i].exp_dout));
      chk("tbl_busy", 64'(last_busy), 64'(tbl[i].exp_busy));
    end
    chk("idle_done_ignored", 64'(dut.state_q), 64'(IDLE));

    // scenario 1: 100 counted cycles plus the done cycle
    quiet(); s_ap = 1; cyc();
    for (int k = 0; k < 100; k++) begin
      s_iv = (k < 40); s_ia = (k < 40); s_ov = (k < 35); s_oa = (k < 30);
      cyc();
    end
    quiet(); s_dn = 1; cyc(); s_dn = 0;
    acc.delete(); pres.delete();
    for (int k = 0; k < HOLD; k++) begin
      s_dn = (k == 3);
      cyc();
    end
    s_dn = 0;
    for (int k = 0; k < 12 && m_phase == 3; k++) cyc();
    chk("s1_count", 64'(acc.size()), 64'd4);
    for (int i = 0; i < acc.size() && i < 4; i++)
      chk("s1_pkt", 64'(acc[i]), 64'(mk_pkt(i, s1_exp[i])));
    drain(4);

    // scenario 2: idx1 rejected three times
    start_burst(20);
    for (int k = 0; k < 20 && m_phase == 3; k++) begin
      s_rs = (pres.size() >= 1 && pres.size() <= 3);
      cyc();
    end
    s_rs = 0;
    n_idx1 = 0;
    foreach (pres[i]) if (pres[i][40:37] == 4'd1) n_idx1++;
    chk("s2_idx1_presented", 64'(n_idx1), 64'd4);
    chk("s2_accepted", 64'(acc.size()), 64'd4);
    for (int i = 0; i < acc.size(); i++) chk("s2_order", 64'(acc[i][40:37]), 64'(i));
    drain(4);

    // scenario 3: user traffic preempts two send slots
    start_burst(15);
    n_pass = 0;
    for (int k = 0; k < 20 && m_phase == 3; k++) begin
      if (acc.size() == 1 && n_pass < 2) begin
        s_sin = {1'b1, 16'($urandom), 32'($urandom)}; n_pass++;
      end else s_sin = '0;
      cyc();
      if (s_sin[48]) chk("s3_passthrough", 64'(last_dout), 64'(s_sin));
    end
    s_sin = '0;
    chk("s3_accepted", 64'(acc.size()), 64'd4);
    for (int i = 0; i < acc.size(); i++) chk("s3_order", 64'(acc[i][40:37]), 64'(i));
    drain(4);

    // scenario 4: cycle counter pushed to its ceiling
    quiet(); s_ap = 0; cyc(); s_ap = 1; cyc(); s_ap = 0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    force dut.cnt_cycles_q = 32'hFFFF_FFFF;
    m_cnt[0] = 64'hFFFF_FFFF;
    cyc();
    release dut.cnt_cycles_q;
    cyc();
    s_dn = 1; cyc(); s_dn = 0;
    for (int k = 0; k < HOLD + 4 && m_phase != 3; k++) cyc();
    acc.delete(); pres.delete();
    for (int k = 0; k < 12 && m_phase == 3; k++) cyc();
    chk("s4_accepted", 64'(acc.size()), 64'd4);
    if (acc.size() > 0) chk("s4_saturated", 64'(acc[0][31:0]), 64'hFFFF_FFFF);
    drain(4);

    // scenario 5: restart after idx1 accepted
    start_burst(10);
    for (int k = 0; k < 10 && m_phase == 3 && acc.size() < 2; k++) cyc();
    s_ap = 1; cyc();
    #1;
    chk("s5_state", 64'(dut.state_q), 64'(COUNT));
    chk("s5_cnt0", 64'(dut.cnt_cycles_q), 64'd0);
    chk("s5_cnt1", 64'(dut.cnt_in_q), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    n_leak = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (last_dout[48]) n_leak++;
    end
    chk("s5_no_packets", 64'(n_leak), 64'd0);
    s_ap = 0; s_dn = 1; cyc(); s_dn = 0;
    drain(HOLD + 12);

    // randomized run against the model
    for (int k = 0; k < 4000; k++) begin
      s_rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 149) == 0) s_ap = ~s_ap;
      s_dn = ($urandom_range(0, 59) == 0);
      s_iv = 1'($urandom); s_ia = 1'($urandom); s_ov = 1'($urandom); s_oa = 1'($urandom);
      s_sin = {($urandom_range(0, 3) == 0), 16'($urandom), 32'($urandom)};
      s_rs = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnt_packet_sender.md
CNT_PACKET_SENDER -- requirements
Module: cnt_packet_sender

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49, BFT packet width.
REQ-002 SHALL have parameter NUM_LEAF_BITS, default 3, leaf address width.
REQ-003 SHALL have parameter NUM_PORT_BITS, default 4, port address width.
REQ-004 SHALL have parameter SELF_LEAF, default 2, this leaf's address.
REQ-005 SHALL have parameter DEST_LEAF, default 1, leaf address of the ydma leaf.
REQ-006 SHALL have parameter DEST_PORT, default 2, destination port at the ydma leaf.
REQ-007 SHALL have parameter HOLDOFF_CYCLES, default 16, idle gap before the counter burst.
REQ-008 SHALL have one clock, clk, and a synchronous active-high reset, reset.
REQ-009 Ports, listed as name, direction, width, meaning:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- ap_start, in, 1, kernel start level.
- done, in, 1, operator-finished pulse.
- in_vld, in, 1, user input-stream valid.
- in_ack, in, 1, user input-stream accept.
- out_vld, in, 1, user output-stream valid.
- out_ack, in, 1, user output-stream accept.
- stream_in, in, PACKET_BITS, normal outbound packet; bit 48 is its valid.
- dout_leaf_interface2bft, out, PACKET_BITS, packet to the BFT.
- resend, in, 1, BFT rejected the packet presented this cycle.
- busy, out, 1, burst pending or in progress.

Function
REQ-010 Counter packet format SHALL be:
- [48] = 1.
- [47:45] = DEST_LEAF.
- [44:41] = DEST_PORT.
- [40:37] = counter index.
- [36:34] = SELF_LEAF.
- [33:32] = 0.
- [31:0] = counter value.
REQ-011 There SHALL be four 32-bit counters:
- idx0: cycles spent in COUNT.
- idx1: cycles with in_vld&in_ack.
- idx2: cycles with out_vld&out_ack.
- idx3: cycles with out_vld&!out_ack.
REQ-012 Counters SHALL saturate at 0xFFFFFFFF and SHALL not wrap.
REQ-013 The FSM states SHALL be IDLE, COUNT, HOLD, SEND, FINISH.
REQ-014 A rising edge of ap_start, detected as a registered edge, SHALL clear all counters and enter COUNT from any state, including mid-SEND. Any burst in progress is abandoned.
REQ-015 COUNT: counters increment; done=1 SHALL latch the counters and enter HOLD.
REQ-016 done SHALL be ignored outside COUNT.
REQ-017 HOLD SHALL last exactly HOLDOFF_CYCLES cycles, then enter SEND with index 0.
REQ-018 SEND: when stream_in[48]=1, stream_in SHALL pass through and the counter packet SHALL be deferred; normal traffic has priority.
REQ-019 SEND: when stream_in[48]=0, the counter packet for the current index SHALL drive dout in the same cycle.
REQ-020 If resend=1 in the cycle a counter packet is driven, the index SHALL hold and the same packet SHALL be re-presented on the next eligible cycle.
REQ-021 If resend=0 in that cycle, the index SHALL advance. After index 3 is accepted, the FSM SHALL enter FINISH.
REQ-022 Resend of pass-through stream_in traffic is the upstream sender's responsibility. The block SHALL be combinational for stream_in (zero latency).
REQ-023 In IDLE, COUNT, HOLD and FINISH, dout SHALL equal stream_in.
REQ-024 FINISH SHALL go to IDLE after one cycle.
REQ-025 busy SHALL be 1 in HOLD and SEND, and 0 otherwise.
REQ-026 Counter packets SHALL occupy exactly 4 accepted BFT slots per burst, which matches num_cnt_read=4 at the ydma leaf.

Reset
REQ-027 On reset, the state SHALL be IDLE, all counters, latches, the index and the holdoff timer SHALL be 0, busy SHALL be 0, and the edge detector register SHALL be 0.
REQ-028 During reset, dout SHALL equal stream_in, with no counter packet emitted.
REQ-029 Reset mid-SEND SHALL drop the remaining packets.

Structure
REQ-030 Packet field offsets, the FSM state encoding and NUM_CNT=4 SHALL live in a shared package, cnt_pkt_pkg.
REQ-031 The rising-edge detector SHALL reuse sub-module rise_detect (data_width=1). The counters and FSM SHALL be inline.

Verification
REQ-032 Scenario 1: ap_start rise, 100 cycles, 40 in handshakes, 30 out handshakes, 5 out stalls, then done, HOLDOFF_CYCLES=16 -> after 16 idle cycles, packets with payload 101, 40, 30, 5 (idx0..3) appear, [47:41] = {3'd1, 4'd2}, [36:34] = 3'd2.
REQ-033 Scenario 2: resend=1 on the idx1 packet for 3 cycles -> idx1 is repeated 3 times, then idx2 follows; exactly 4 distinct packets are accepted.
REQ-034 Scenario 3: stream_in valid on 2 cycles during SEND -> those cycles carry stream_in unmodified, and the counter sequence resumes intact.
REQ-035 Scenario 4: force idx0 count past 0xFFFFFFFF -> payload = 0xFFFFFFFF.
REQ-036 Scenario 5: ap_start re-rise after idx1 is sent -> no further counter packets, counters = 0, state COUNT, busy = 0.
REQ-037 Scenario 6: done pulse in IDLE, or a second done in HOLD -> no effect, and exactly one 4-packet burst is sent.
